// File: rtl/pipelined_mul_acc_if.sv
// rtl/pipelined_mul_acc_if.sv - operand/result bundle for pipelined_mul_acc
//
// Carries the clock enable, the qualified operand beat (i_valid, a, b,
// acc_en, clr) and the registered result (o, o_valid, ovf).
//   master : drives ce/i_valid/a/b/acc_en/clr, observes o/o_valid/ovf
//   slave  : the multiply/accumulate pipeline
interface pipelined_mul_acc_if #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 40
);
    logic             ce;
    logic             i_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_en;
    logic             clr;
    logic [OUT_W-1:0] o;
    logic             o_valid;
    logic             ovf;

    modport master (
        output ce, i_valid, a, b, acc_en, clr,
        input  o, o_valid, ovf
    );

    modport slave (
        input  ce, i_valid, a, b, acc_en, clr,
        output o, o_valid, ovf
    );
endinterface

// File: rtl/pipelined_mul_acc.sv
// rtl/pipelined_mul_acc.sv - parametrised multiply/accumulate pipeline
//
// Unsigned a*b, zero-extended to OUT_W, optionally added to the running
// accumulator. DEPTH register stages from operand to o:
//   DEPTH=1 : accumulator only (multiply is combinational into it)
//   DEPTH=2 : product register + accumulator
//   DEPTH=3 : operand register + product register + accumulator
//   DEPTH=4 : two operand registers + product register + accumulator
// A valid bit and the acc_en/clr controls travel alongside each beat.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every stage and o/o_valid/ovf
//   bus    pipelined_mul_acc_if.slave
//            ce      0 freezes all stages including valid bits
//            i_valid qualifies a/b/acc_en/clr this cycle
//            a, b    WIDTH-bit unsigned operands
//            acc_en  1: o <= o + a*b, 0: o <= a*b
//            clr     restart from a*b, overrides acc_en
//            o       OUT_W-bit result register
//            o_valid o holds a new result this cycle
//            ovf     the result on o overflowed OUT_W
//
// Build option PIPELINED_MUL_ACC_SATURATE_EN:
//   defined   - an accumulate carry-out clamps o to all ones (ovf=1)
//   undefined - o wraps modulo 2^OUT_W (ovf=1 on the wrapping result)
module pipelined_mul_acc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter int OUT_W = 40
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipelined_mul_acc_if.slave      bus
);
    // Operand stages sit ahead of the multiply only for DEPTH>=3.
    localparam int N_OP = (DEPTH >= 3) ? DEPTH - 2 : 0;
    localparam int P_W  = 2 * WIDTH;

    // Index 0 is the raw input; index k is the output of operand stage k.
    logic [WIDTH-1:0] w_op_a   [0:N_OP];
    logic [WIDTH-1:0] w_op_b   [0:N_OP];
    logic             w_op_v   [0:N_OP];
    logic             w_op_acc [0:N_OP];
    logic             w_op_clr [0:N_OP];

    assign w_op_a[0]   = bus.a;
    assign w_op_b[0]   = bus.b;
    assign w_op_v[0]   = bus.i_valid;
    assign w_op_acc[0] = bus.acc_en;
    assign w_op_clr[0] = bus.clr;

    genvar gi;
    generate
        for (gi = 1; gi <= N_OP; gi++) begin : g_op
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic             r_v;
            logic             r_acc;
            logic             r_clr;

            // Data moves even when invalid; only the valid bit gates the accumulator.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_v   <= 1'b0;
                    r_acc <= 1'b0;
                    r_clr <= 1'b0;
                end else if (bus.ce) begin
                    r_a   <= w_op_a[gi-1];
                    r_b   <= w_op_b[gi-1];
                    r_v   <= w_op_v[gi-1];
                    r_acc <= w_op_acc[gi-1];
                    r_clr <= w_op_clr[gi-1];
                end
            end

            assign w_op_a[gi]   = r_a;
            assign w_op_b[gi]   = r_b;
            assign w_op_v[gi]   = r_v;
            assign w_op_acc[gi] = r_acc;
            assign w_op_clr[gi] = r_clr;
        end
    endgenerate

    // Full-width unsigned product of the last operand stage.
    logic [P_W-1:0] w_mul;
    assign w_mul = P_W'(w_op_a[N_OP]) * P_W'(w_op_b[N_OP]);

    // Product as seen by the accumulator stage.
    logic [P_W-1:0] w_fin_p;
    logic           w_fin_v;
    logic           w_fin_acc;
    logic           w_fin_clr;

    generate
        if (DEPTH >= 2) begin : g_prod
            logic [P_W-1:0] r_prod;
            logic           r_v;
            logic           r_acc;
            logic           r_clr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prod <= '0;
                    r_v    <= 1'b0;
                    r_acc  <= 1'b0;
                    r_clr  <= 1'b0;
                end else if (bus.ce) begin
                    r_prod <= w_mul;
                    r_v    <= w_op_v[N_OP];
                    r_acc  <= w_op_acc[N_OP];
                    r_clr  <= w_op_clr[N_OP];
                end
            end

            assign w_fin_p   = r_prod;
            assign w_fin_v   = r_v;
            assign w_fin_acc = r_acc;
            assign w_fin_clr = r_clr;
        end else begin : g_no_prod
            assign w_fin_p   = w_mul;
            assign w_fin_v   = w_op_v[N_OP];
            assign w_fin_acc = w_op_acc[N_OP];
            assign w_fin_clr = w_op_clr[N_OP];
        end
    endgenerate

    // Accumulator stage. The sum is one bit wider than o so its top bit is
    // the carry-out that signals overflow.
    logic [OUT_W-1:0] r_o;
    logic             r_o_valid;
    logic             r_ovf;

    logic [OUT_W-1:0] w_p_ext;
    logic [OUT_W:0]   w_sum;
    logic [OUT_W-1:0] w_o_next;
    logic             w_ovf_next;

    assign w_p_ext = OUT_W'(w_fin_p);
    assign w_sum   = {1'b0, r_o} + {1'b0, w_p_ext};

    always_comb begin
        // A product alone always fits in OUT_W, so restarting never overflows.
        w_o_next   = w_p_ext;
        w_ovf_next = 1'b0;
        if (w_fin_acc && !w_fin_clr) begin
`ifdef PIPELINED_MUL_ACC_SATURATE_EN
            if (w_sum[OUT_W]) begin
                w_o_next   = '1;
                w_ovf_next = 1'b1;
            end else begin
                w_o_next   = w_sum[OUT_W-1:0];
            end
`else
            w_o_next   = w_sum[OUT_W-1:0];
            w_ovf_next = w_sum[OUT_W];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o       <= '0;
            r_o_valid <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (bus.ce) begin
            r_o_valid <= w_fin_v;
            if (w_fin_v) begin
                r_o   <= w_o_next;
                r_ovf <= w_ovf_next;
            end else begin
                // Bubble: o keeps the last result, the overflow flag is per-result.
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.o       = r_o;
    assign bus.o_valid = r_o_valid;
    assign bus.ovf     = r_ovf;
endmodule
